// File: rtl/mini_src_ctrl_pkg.sv
// Shared control definitions for the Mini SRC register-to-register sequencer.
// ALU_RR_MULDIV_EN adds MUL/DIV decode and the T6 (HI write) state.
package mini_src_ctrl_pkg;

`ifdef ALU_RR_MULDIV_EN
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_T0   = 3'd1,
        ST_T1   = 3'd2,
        ST_T2   = 3'd3,
        ST_T3   = 3'd4,
        ST_T4   = 3'd5,
        ST_T5   = 3'd6,
        ST_T6   = 3'd7
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_T0   = 3'd1,
        ST_T1   = 3'd2,
        ST_T2   = 3'd3,
        ST_T3   = 3'd4,
        ST_T4   = 3'd5,
        ST_T5   = 3'd6
    } state_t;
`endif

    localparam logic [4:0] BUS_HI  = 5'd16;
    localparam logic [4:0] BUS_LO  = 5'd17;
    localparam logic [4:0] BUS_ZHI = 5'd18;
    localparam logic [4:0] BUS_ZLO = 5'd19;
    localparam logic [4:0] BUS_PC  = 5'd20;
    localparam logic [4:0] BUS_MDR = 5'd21;

    localparam logic [4:0] OP_ADD  = 5'd3;
    localparam logic [4:0] OP_SUB  = 5'd5;
    localparam logic [4:0] OP_LAST = 5'd12;
    localparam logic [4:0] OP_MUL  = 5'd15;
    localparam logic [4:0] OP_DIV  = 5'd16;

    typedef struct packed {
        logic       legal;
        logic [3:0] op;
    } alu_dec_t;

    // Plain ALU opcodes map to opcode-1; MUL/DIV land on 14/15 by the same rule.
    function automatic alu_dec_t decode_alu_op(input logic [4:0] opcode);
        alu_dec_t d;
        d.legal = 1'b0;
        d.op    = 4'd0;
        case (opcode) inside
            [OP_ADD:OP_LAST]: begin
                d.legal = 1'b1;
                d.op    = 4'(opcode - 5'd1);
            end
`ifdef ALU_RR_MULDIV_EN
            OP_MUL, OP_DIV: begin
                d.legal = 1'b1;
                d.op    = 4'(opcode - 5'd1);
            end
`endif
            default: begin
                d.legal = 1'b0;
                d.op    = 4'd0;
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/alu_rr_wait_timer.sv
// T1 memory-wait counter: counts T1 cycles without mem_ready and flags the timeout.
module alu_rr_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk_i,
    input  logic clr_i,
    input  logic in_t1_i,
    input  logic mem_ready_i,
    output logic first_o,
    output logic timeout_o
);
    localparam int CW = 8;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Outside T1 the counter sits at zero, so every T1 entry starts a fresh count.
    always_comb begin
        cnt_d = cnt_q;
        if (!in_t1_i) begin
            cnt_d = '0;
        end else if (!mem_ready_i && !timeout_o) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or posedge clr_i) begin
        if (clr_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign first_o   = (cnt_q == 8'd0);
    assign timeout_o = (cnt_q == CW'(MEM_TIMEOUT));

endmodule

// File: rtl/alu_rr_sequencer.sv
// Mini SRC register-to-register ALU control sequencer (fetch T0-T2, execute T3-T5/T6).
// Define ALU_RR_MULDIV_EN to enable MUL/DIV with the LO/HI write-back states.
module alu_rr_sequencer
    import mini_src_ctrl_pkg::*;
#(
    parameter int GP_AW       = 4,
    parameter int BUS_SEL_W   = 5,
    parameter int ALU_OP_W    = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                 clock,
    input  logic                 clear,
    input  logic                 start,
    input  logic                 mem_ready,
    input  logic [31:0]          ir,
    output logic [BUS_SEL_W-1:0] bus_sel,
    output logic [GP_AW-1:0]     gp_addr,
    output logic                 e_PC,
    output logic                 e_IR,
    output logic                 e_Y,
    output logic                 e_Z,
    output logic                 e_HI,
    output logic                 e_LO,
    output logic                 e_MDR,
    output logic                 e_MAR,
    output logic                 e_GP,
    output logic                 inc_pc,
    output logic                 mdr_read,
    output logic [ALU_OP_W-1:0]  alu_op,
    output logic                 busy,
    output logic                 done,
    output logic                 illegal,
    output logic                 fault
);
    state_t state_q;
    state_t state_d;

    logic [4:0] opcode_s;
    logic [3:0] ra_s;
    logic [3:0] rb_s;
    logic [3:0] rc_s;
    alu_dec_t   dec_s;
    logic       muldiv_s;
    logic       first_s;
    logic       timeout_s;
    logic       unused_s;

    logic [4:0] bus_sel_s;
    logic [3:0] gp_addr_s;
    logic [3:0] alu_op_s;
    logic       e_pc_s, e_ir_s, e_y_s, e_z_s, e_hi_s, e_lo_s;
    logic       e_mdr_s, e_mar_s, e_gp_s, inc_pc_s, mdr_read_s;
    logic       busy_s, done_s, illegal_s, fault_s;

    assign opcode_s = ir[31:27];
    assign ra_s     = ir[26:23];
    assign rb_s     = ir[22:19];
    assign rc_s     = ir[18:15];
    assign unused_s = ^ir[14:0];
    assign dec_s    = decode_alu_op(opcode_s);

`ifdef ALU_RR_MULDIV_EN
    assign muldiv_s = (opcode_s == OP_MUL) || (opcode_s == OP_DIV);
`else
    assign muldiv_s = 1'b0;
`endif

    alu_rr_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_wait_timer (
        .clk_i       (clock),
        .clr_i       (clear),
        .in_t1_i     (state_q == ST_T1),
        .mem_ready_i (mem_ready),
        .first_o     (first_s),
        .timeout_o   (timeout_s)
    );

    // State register; clear drops straight to IDLE so no enable survives it.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_T0;
                else       state_d = ST_IDLE;
            end
            ST_T0: state_d = ST_T1;
            ST_T1: begin
                // mem_ready takes priority over a timeout hit in the same cycle
                if (mem_ready)      state_d = ST_T2;
                else if (timeout_s) state_d = ST_IDLE;
                else                state_d = ST_T1;
            end
            ST_T2: state_d = ST_T3;
            ST_T3: begin
                if (dec_s.legal) state_d = ST_T4;
                else             state_d = ST_IDLE;
            end
            ST_T4: state_d = ST_T5;
            ST_T5: begin
`ifdef ALU_RR_MULDIV_EN
                if (muldiv_s)   state_d = ST_T6;
                else if (start) state_d = ST_T0;
                else            state_d = ST_IDLE;
`else
                if (start) state_d = ST_T0;
                else       state_d = ST_IDLE;
`endif
            end
`ifdef ALU_RR_MULDIV_EN
            ST_T6: begin
                if (start) state_d = ST_T0;
                else       state_d = ST_IDLE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode from the state register (plus IR fields and the wait timer).
    always_comb begin
        bus_sel_s  = 5'd0;
        gp_addr_s  = 4'd0;
        alu_op_s   = 4'd0;
        e_pc_s     = 1'b0;
        e_ir_s     = 1'b0;
        e_y_s      = 1'b0;
        e_z_s      = 1'b0;
        e_hi_s     = 1'b0;
        e_lo_s     = 1'b0;
        e_mdr_s    = 1'b0;
        e_mar_s    = 1'b0;
        e_gp_s     = 1'b0;
        inc_pc_s   = 1'b0;
        mdr_read_s = 1'b0;
        busy_s     = 1'b1;
        done_s     = 1'b0;
        illegal_s  = 1'b0;
        fault_s    = 1'b0;
        case (state_q)
            ST_IDLE: busy_s = 1'b0;
            ST_T0: begin
                bus_sel_s = BUS_PC;
                e_mar_s   = 1'b1;
                inc_pc_s  = 1'b1;
                e_z_s     = 1'b1;
            end
            ST_T1: begin
                bus_sel_s  = BUS_ZLO;
                e_pc_s     = first_s;
                mdr_read_s = 1'b1;
                e_mdr_s    = 1'b1;
                fault_s    = timeout_s & ~mem_ready;
            end
            ST_T2: begin
                bus_sel_s = BUS_MDR;
                e_ir_s    = 1'b1;
            end
            ST_T3: begin
                if (dec_s.legal) begin
                    bus_sel_s = {1'b0, rb_s};
                    e_y_s     = 1'b1;
                end else begin
                    illegal_s = 1'b1;
                end
            end
            ST_T4: begin
                bus_sel_s = {1'b0, rc_s};
                alu_op_s  = dec_s.op;
                e_z_s     = 1'b1;
            end
            ST_T5: begin
                bus_sel_s = BUS_ZLO;
                if (muldiv_s) begin
                    e_lo_s = 1'b1;
                end else begin
                    gp_addr_s = ra_s;
                    e_gp_s    = 1'b1;
                    done_s    = 1'b1;
                end
            end
`ifdef ALU_RR_MULDIV_EN
            ST_T6: begin
                bus_sel_s = BUS_ZHI;
                e_hi_s    = 1'b1;
                done_s    = 1'b1;
            end
`endif
            default: busy_s = 1'b0;
        endcase
    end

    assign bus_sel  = BUS_SEL_W'(bus_sel_s);
    assign gp_addr  = GP_AW'(gp_addr_s);
    assign alu_op   = ALU_OP_W'(alu_op_s);
    assign e_PC     = e_pc_s;
    assign e_IR     = e_ir_s;
    assign e_Y      = e_y_s;
    assign e_Z      = e_z_s;
    assign e_HI     = e_hi_s;
    assign e_LO     = e_lo_s;
    assign e_MDR    = e_mdr_s;
    assign e_MAR    = e_mar_s;
    assign e_GP     = e_gp_s;
    assign inc_pc   = inc_pc_s;
    assign mdr_read = mdr_read_s;
    assign busy     = busy_s;
    assign done     = done_s;
    assign illegal  = illegal_s;
    assign fault    = fault_s;

endmodule

// File: tb/tb_alu_rr_sequencer.sv
// Self-checking bench for alu_rr_sequencer: instruction-level model plus literal pins.
module tb_alu_rr_sequencer;
    localparam int TMO = 15;
`ifdef ALU_RR_MULDIV_EN
    localparam bit MULDIV = 1'b1;
`else
    localparam bit MULDIV = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        clear, start, mem_ready;
    logic [31:0] ir;
    logic [4:0]  bus_sel;
    logic [3:0]  gp_addr, alu_op;
    logic        e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR, e_GP;
    logic        inc_pc, mdr_read, busy, done, illegal, fault;

    alu_rr_sequencer #(
        .GP_AW(4), .BUS_SEL_W(5), .ALU_OP_W(4), .MEM_TIMEOUT(TMO)
    ) dut (
        .clock(clock), .clear(clear), .start(start), .mem_ready(mem_ready), .ir(ir),
        .bus_sel(bus_sel), .gp_addr(gp_addr),
        .e_PC(e_PC), .e_IR(e_IR), .e_Y(e_Y), .e_Z(e_Z), .e_HI(e_HI), .e_LO(e_LO),
        .e_MDR(e_MDR), .e_MAR(e_MAR), .e_GP(e_GP),
        .inc_pc(inc_pc), .mdr_read(mdr_read), .alu_op(alu_op),
        .busy(busy), .done(done), .illegal(illegal), .fault(fault)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [4:0] bus;
        logic [3:0] gp;
        logic [3:0] op;
        logic e_pc, e_ir, e_y, e_z, e_hi, e_lo, e_mdr, e_mar, e_gp;
        logic inc, mrd, busy, done, ill, flt;
    } obs_t;

    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;
    int    start_ref = 0;
    int    done_lat, flt_lat, ill_lat;
    bit    chk_en = 1'b0;
    obs_t  exp_r;
    obs_t  snap4, snap5;
    string tag = "";

    function automatic obs_t dut_obs();
        obs_t o;
        o.bus = bus_sel; o.gp = gp_addr; o.op = alu_op;
        o.e_pc = e_PC; o.e_ir = e_IR; o.e_y = e_Y; o.e_z = e_Z; o.e_hi = e_HI;
        o.e_lo = e_LO; o.e_mdr = e_MDR; o.e_mar = e_MAR; o.e_gp = e_GP;
        o.inc = inc_pc; o.mrd = mdr_read; o.busy = busy; o.done = done;
        o.ill = illegal; o.flt = fault;
        return o;
    endfunction

    always @(posedge clock) cyc <= cyc + 1;

    // Single compare process: DUT outputs against the model's expectation each cycle.
    always @(negedge clock) begin
        if (chk_en) begin
            total++;
            if (dut_obs() !== exp_r) begin
                bad++;
                $display("FAIL %s: got %h want %h", tag, dut_obs(), exp_r);
            end
            if (done === 1'b1)    done_lat = cyc - start_ref;
            if (fault === 1'b1)   flt_lat  = cyc - start_ref;
            if (illegal === 1'b1) ill_lat  = cyc - start_ref;
            if (tag == "sub:T4") snap4 = dut_obs();
            if (tag == "sub:T5") snap5 = dut_obs();
        end
    end

    task automatic chk(input string nm, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask

    task automatic step(input logic st, input logic mr, input obs_t e, input string nm);
        start = st; mem_ready = mr; exp_r = e; tag = nm; chk_en = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic idle(input logic st, input string nm);
        obs_t o;
        o = '0;
        if (st) start_ref = cyc;
        step(st, 1'b0, o, nm);
    endtask

    // Model of one instruction from T0: waits = T1 cycles without mem_ready.
    task automatic run_instr(input logic [31:0] irv, input int waits, input bit chain,
                             input bit stop4, input string nm);
        obs_t o;
        int   opc;
        bit   md, legal;
        opc   = int'(irv[31:27]);
        md    = MULDIV && (opc == 15 || opc == 16);
        legal = (opc >= 3 && opc <= 12) || md;
        ir    = irv;
        o = '0; o.busy = 1; o.bus = 5'd20; o.e_mar = 1; o.inc = 1; o.e_z = 1;
        step(1'b0, 1'b0, o, {nm, ":T0"});
        for (int k = 0; k <= TMO; k++) begin
            o = '0; o.busy = 1; o.bus = 5'd19; o.mrd = 1; o.e_mdr = 1; o.e_pc = (k == 0);
            if (k == waits) begin
                step(1'b0, 1'b1, o, {nm, ":T1"});
                break;
            end
            if (k == TMO) begin
                o.flt = 1;
                step(1'b0, 1'b0, o, {nm, ":T1tmo"});
                return;
            end
            step(1'b0, 1'b0, o, {nm, ":T1w"});
        end
        o = '0; o.busy = 1; o.bus = 5'd21; o.e_ir = 1;
        step(1'b0, 1'b0, o, {nm, ":T2"});
        o = '0; o.busy = 1;
        if (!legal) begin
            o.ill = 1;
            step(1'b0, 1'b0, o, {nm, ":T3ill"});
            return;
        end
        o.bus = {1'b0, irv[22:19]}; o.e_y = 1;
        step(1'b0, 1'b0, o, {nm, ":T3"});
        if (stop4) return;
        o = '0; o.busy = 1; o.bus = {1'b0, irv[18:15]}; o.op = 4'(opc - 1); o.e_z = 1;
        step(1'b0, 1'b0, o, {nm, ":T4"});
        o = '0; o.busy = 1; o.bus = 5'd19;
        if (md) o.e_lo = 1;
        else begin o.gp = irv[26:23]; o.e_gp = 1; o.done = 1; end
        step(chain && !md, 1'b0, o, {nm, ":T5"});
        if (md) begin
            o = '0; o.busy = 1; o.bus = 5'd18; o.e_hi = 1; o.done = 1;
            step(chain, 1'b0, o, {nm, ":T6"});
        end
    endtask

    task automatic clr_lat();
        done_lat = -1; flt_lat = -1; ill_lat = -1;
    endtask

    localparam logic [31:0] IR_SUB = 32'h2A1B8000;
    localparam logic [31:0] IR_ADD = {5'd3, 4'd9, 4'd10, 4'd11, 15'd0};
    localparam logic [31:0] IR_L12 = {5'd12, 4'd15, 4'd0, 4'd1, 15'd0};
    localparam logic [31:0] IR_13  = {5'd13, 4'd1, 4'd2, 4'd3, 15'd0};
    localparam logic [31:0] IR_02  = {5'd2, 4'd1, 4'd2, 4'd3, 15'd0};
    localparam logic [31:0] IR_BAD = {5'b11111, 4'd1, 4'd2, 4'd3, 15'd0};
    localparam logic [31:0] IR_MUL = {5'b01111, 4'd0, 4'd2, 4'd5, 15'd0};
    localparam logic [31:0] IR_DIV = {5'b10000, 4'd6, 4'd4, 4'd8, 15'd0};

    initial begin
        clear = 1'b1; start = 1'b0; mem_ready = 1'b0; ir = '0;
        clr_lat();
        #1;
        chk("reset_outputs", int'(dut_obs()), 0);
        repeat (2) @(posedge clock);
        #1;
        clear = 1'b0;
        idle(1'b0, "idle0");

        clr_lat(); idle(1'b1, "sub_go");
        run_instr(IR_SUB, 0, 1'b0, 1'b0, "sub");
        chk("sub_done_lat", done_lat, 6);
        chk("sub_T4_bus", int'(snap4.bus), 7);
        chk("sub_T4_aluop", int'(snap4.op), 4);
        chk("sub_T5_gp", int'(snap5.gp), 4);
        chk("sub_T5_bus", int'(snap5.bus), 19);
        idle(1'b0, "idle1");

        clr_lat(); idle(1'b1, "w3_go");
        run_instr(IR_SUB, 3, 1'b0, 1'b0, "sub_w3");
        chk("wait3_done_lat", done_lat, 9);

        clr_lat(); idle(1'b1, "w15_go");
        run_instr(IR_ADD, TMO, 1'b0, 1'b0, "add_w15");
        chk("wait15_done_lat", done_lat, 21);
        chk("wait15_no_fault", flt_lat, -1);

        clr_lat(); idle(1'b1, "tmo_go");
        run_instr(IR_SUB, 1000, 1'b0, 1'b0, "tmo");
        chk("timeout_fault_lat", flt_lat, 17);
        idle(1'b0, "after_tmo");

        clr_lat(); idle(1'b1, "bad_go");
        run_instr(IR_BAD, 0, 1'b0, 1'b0, "op31");
        chk("illegal_lat", ill_lat, 4);
        idle(1'b0, "after_ill");

        clr_lat(); idle(1'b1, "op13_go");
        run_instr(IR_13, 1, 1'b0, 1'b0, "op13");
        chk("op13_illegal", ill_lat, 5);
        clr_lat(); idle(1'b1, "op2_go");
        run_instr(IR_02, 0, 1'b0, 1'b0, "op2");
        chk("op2_illegal", ill_lat, 4);
        clr_lat(); idle(1'b1, "op12_go");
        run_instr(IR_L12, 0, 1'b0, 1'b0, "op12");
        chk("op12_done_lat", done_lat, 6);

        clr_lat(); idle(1'b1, "mul_go");
        run_instr(IR_MUL, 0, 1'b0, 1'b0, "mul");
        if (MULDIV) chk("mul_done_lat", done_lat, 7);
        else        chk("mul_illegal_lat", ill_lat, 4);
        clr_lat(); idle(1'b1, "div_go");
        run_instr(IR_DIV, 2, 1'b0, 1'b0, "div");
        if (MULDIV) chk("div_done_lat", done_lat, 9);
        else        chk("div_illegal_lat", ill_lat, 6);
        idle(1'b0, "after_md");

        clr_lat(); idle(1'b1, "b2b_go");
        run_instr(IR_ADD, 0, 1'b1, 1'b0, "b2b_a");
        start_ref = cyc - 1;
        run_instr(IR_SUB, 1, 1'b0, 1'b0, "b2b_b");
        chk("b2b_second_done_lat", done_lat, 7);
        idle(1'b0, "after_b2b");

        idle(1'b1, "clr_go");
        run_instr(IR_SUB, 0, 1'b0, 1'b1, "clr");
        chk_en = 1'b0; start = 1'b0; mem_ready = 1'b0;
        #1;
        chk("pre_clear_T4_ez", int'(e_Z), 1);
        #1 clear = 1'b1;
        #1;
        chk("clear_async_outputs", int'(dut_obs()), 0);
        #2 clear = 1'b0;
        @(posedge clock); #1;
        idle(1'b0, "after_clear");

        clr_lat(); idle(1'b1, "post_clr_go");
        run_instr(IR_ADD, 0, 1'b0, 1'b0, "post_clr");
        chk("post_clear_done_lat", done_lat, 6);
        idle(1'b0, "final_idle");

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
